// File: rtl/ama_riscv_hazard_scoreboard.sv
// Multi-stage forwarding select and load-use stall generator for the ID stage.
// Optional stall counter: define AMA_RISCV_HAZ_PERF_CNT_EN to build it.
module ama_riscv_hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int RF_ADDR_W  = 5,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [NUM_SRC*RF_ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [RF_ADDR_W-1:0]         id_rd_addr,
    input  logic                         id_reg_we,
    input  logic                         id_load,
    input  logic                         pipe_adv,
    input  logic                         flush,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic                         stall_id,
    output logic [31:0]                  stall_cnt
);

    // Stage s of the in-flight tracker; index 1 is EX.
    logic [FWD_STAGES:1]  vld_q, we_q, ld_q;
    logic [RF_ADDR_W-1:0] rd_q [1:FWD_STAGES];

    logic [NUM_SRC-1:0]   hazard;
    logic [SEL_W-1:0]     sel_v;
    logic                 rdy_v;
    logic [RF_ADDR_W-1:0] addr_v;

    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        sel_v   = '0;
        rdy_v   = 1'b1;
        addr_v  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_v  = '0;
            rdy_v  = 1'b1;
            addr_v = id_rs_addr[i*RF_ADDR_W +: RF_ADDR_W];
            // Oldest first so the youngest match overwrites it.
            for (int s = FWD_STAGES; s >= 1; s--) begin
                if (vld_q[s] && we_q[s] && (rd_q[s] == addr_v) && (addr_v != '0)) begin
                    sel_v = SEL_W'(s);
                    rdy_v = !ld_q[s] || (s > LOAD_LAT);
                end
            end
            if (id_valid && id_rs_used[i]) begin
                fwd_sel[i*SEL_W +: SEL_W] = sel_v;
            end
            hazard[i] = id_rs_used[i] && !rdy_v;
        end
    end

    assign stall_id = id_valid && !flush && (|hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            we_q  <= '0;
            ld_q  <= '0;
            for (int s = 1; s <= FWD_STAGES; s++) begin
                rd_q[s] <= '0;
            end
        end else if (pipe_adv) begin
            // A stalled or flushed ID instruction enters EX as a bubble.
            vld_q[1] <= id_valid && !stall_id && !flush;
            rd_q[1]  <= id_rd_addr;
            we_q[1]  <= id_reg_we;
            ld_q[1]  <= id_load;
            for (int s = 2; s <= FWD_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                rd_q[s]  <= rd_q[s-1];
                we_q[s]  <= we_q[s-1];
                ld_q[s]  <= ld_q[s-1];
            end
        end
    end

`ifdef AMA_RISCV_HAZ_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && pipe_adv && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/ama_riscv_hazard_scoreboard.md
# ama_riscv_hazard_scoreboard

Parametrised successor to the single-stage operand forwarding logic. It tracks the destination register, write-enable and load flag of every in-flight instruction from EX through `FWD_STAGES` pipeline stages. For each ID-stage source operand it produces a forward select naming the youngest producing stage. It raises `stall_id` when the youngest producer is a load whose data is not yet available, which is the load-use hazard. It sits beside the ID/EX pipeline registers and drives the operand, branch-compare and store-data forwarding muxes.

## Interface

Parameters:

- `NUM_SRC`, default 2: number of ID source operands (rs1, rs2, ...).
- `FWD_STAGES`, default 2: tracked stages. Stage 1 is EX, stage 2 is MEM, and so on.
- `LOAD_LAT`, default 1: stages after EX before load data is forwardable. Legal only if `LOAD_LAT < FWD_STAGES`.
- `RF_ADDR_W`, default 5: register address width.
- `SEL_W` (derived) = `$clog2(FWD_STAGES+1)`.

Ports:

- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_rs_addr`  in  `NUM_SRC*RF_ADDR_W`  source addresses. Operand i occupies bits `[i*RF_ADDR_W +: RF_ADDR_W]`.
- `id_rs_used`  in  `NUM_SRC`  operand i is actually read from the register file. It is 0 for imm/pc-selected operands.
- `id_rd_addr`  in  `RF_ADDR_W`  ID destination register.
- `id_reg_we`  in  1  ID instruction writes `rd`.
- `id_load`  in  1  ID instruction is a load.
- `pipe_adv`  in  1  pipeline advances this cycle. When 0, the whole pipeline is frozen.
- `flush`  in  1  kill the ID instruction (redirect).
- `fwd_sel`  out  `NUM_SRC*SEL_W`  per operand: 0 = register file, s = forward from stage s.
- `stall_id`  out  1  hold IF/ID and insert a bubble into EX.
- `stall_cnt`  out  32  load-use stall cycle count. See Configuration.

## Operation

- Tracking state: one entry per stage s = 1..`FWD_STAGES`. Each entry holds `{vld, rd, we, ld}`.
- An entry is a producer for address a when all of the following hold:
  - `vld && we`
  - `rd == a`
  - `a != 0` (x0 is never forwarded or stalled on)
- A producer's result is ready when either condition holds:
  - `!ld`
  - `s > LOAD_LAT`
- Per-operand select, operand i:
  - If `!id_valid` or `!id_rs_used[i]`, then `fwd_sel[i]` = 0.
  - Otherwise `fwd_sel[i]` = the smallest s with a producer (youngest wins), or 0 if there is none.
- Hazard on operand i: `id_rs_used[i]` and the youngest producer is not ready.
- `stall_id = id_valid && !flush && (OR of hazards over all operands)`.
- When `stall_id` is 1, `fwd_sel` values are don't-care for the consumer, but they must still follow the rule above.
- Register file is write-before-read. An address with no producer in stages 1..`FWD_STAGES` reads the register file (sel 0).
- Update on the `clk` posedge, only when `pipe_adv` = 1:
  - `stage[s] <= stage[s-1]` for s ≥ 2. The oldest entry is discarded.
  - `stage[1] <= {id_valid && !stall_id && !flush, id_rd_addr, id_reg_we, id_load}`. When vld = 0 the entry is a bubble.
- `pipe_adv` = 0: all state holds, and outputs are recomputed from the held state and the current ID inputs.
- `flush` during a hazard: `stall_id` = 0 and a bubble enters stage 1.

## Timing

- `fwd_sel` and `stall_id` are combinational from ID inputs and registered stage state. They are valid in the same cycle. There is no input-to-output register.
- State latency: an instruction that leaves ID at edge N is stage s for the cycle after edge N+s-1, counted in advancing edges only.
- Load-use stall length: `LOAD_LAT - s + 1` advancing cycles when the load sits in stage s ≤ `LOAD_LAT`. With defaults this is exactly 1 cycle.
- Reset (`rst_n` low, asynchronous, valid mid-operation):
  - All stage `vld` bits are cleared immediately.
  - `fwd_sel` = 0, `stall_id` = 0 while `id_valid` = 0 or no producer exists.
  - `stall_cnt` = 0.
- Release of `rst_n` is synchronised externally. The first state update is at the first posedge with `rst_n` high and `pipe_adv` = 1.

## Configuration

- `AMA_RISCV_HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each posedge with `stall_id && pipe_adv`.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Not defined:
  - No counter flops are built.
  - The `stall_cnt` port still exists and is tied to 0.

## Test plan

All scenarios use the default parameters.

- ALU chain. `add x5` issues, next ID reads rs1 = x5 -> `fwd_sel[0]` = 1, `stall_id` = 0. One cycle later, same read -> sel 2. Two cycles later -> sel 0.
- Load-use. `lw x7` issues, next ID reads rs2 = x7 -> `stall_id` = 1 for one cycle and stage 1 holds a bubble. Next cycle -> `stall_id` = 0, `fwd_sel[1]` = 2.
- Priority and masking:
  - x5 is written by both stage 1 and stage 2 -> sel 1.
  - rd = x0 writer, ID reads x0 -> sel 0.
  - `id_rs_used` = 0 on a matching operand -> sel 0, no stall.
- Freeze and flush:
  - Load-use hazard active, `pipe_adv` = 0 for 3 cycles -> `stall_id` stays 1 and state is unchanged.
  - Then assert `flush` -> `stall_id` = 0, and stage 1 becomes a bubble at the next advance.
- Reset mid-operation. Assert `rst_n` = 0 with both stages valid -> `stall_id` = 0, all `fwd_sel` = 0, `stall_cnt` = 0 before the next edge.
- Counter, with the macro defined: 3 separate load-use hazards -> `stall_cnt` = 3. Without the macro -> `stall_cnt` = 0 throughout.
